// File: rtl/axi4_tracker_pkg.sv
// axi4_tracker_pkg: shared helpers, derived sizes and channel enum for the AXI4 user tracker
package axi4_tracker_pkg;
  typedef enum logic {CH_RD = 1'b0, CH_WR = 1'b1} channel_e;
  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction
  function automatic int num_ids(input int id_w);
    return 1 << id_w;
  endfunction
  function automatic int cnt_w(input int id_w, input int depth);
    return clog2(num_ids(id_w) * depth + 1);
  endfunction
  localparam int NUM_IDS_DEF = num_ids(2);
  localparam int CNT_W_DEF = cnt_w(2, 2);
endpackage

// File: rtl/axi4_user_fifo.sv
// axi4_user_fifo: DEPTH-entry user-bit queue for one ID on one channel
module axi4_user_fifo
  import axi4_tracker_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int USER_W = 5,
  localparam int QW = clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              push,
  input  logic [USER_W-1:0] push_data,
  input  logic              pop,
  output logic [USER_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [QW-1:0]     count
);
  logic [USER_W-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  assign head = mem[rd_ptr];
  assign full = count == QW'(DEPTH);
  assign empty = count == '0;
  // storage is only meaningful below count, so it needs no reset
  always_ff @(posedge clock)
    if (push) mem[wr_ptr] <= push_data;
  // pointers wrap modulo DEPTH; a push and pop together leave count unchanged
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      count <= count + QW'(push) - QW'(pop);
    end
endmodule

// File: rtl/axi4_id_user_tracker.sv
// axi4_id_user_tracker: records AR/AW user bits per ID and returns them on the matching R/B
module axi4_id_user_tracker
  import axi4_tracker_pkg::*;
#(
  parameter int ID_W = 2,
  parameter int DEPTH = 2,
  parameter int USER_W = 5,
  localparam int NUM_IDS = num_ids(ID_W),
  localparam int CNT_W = cnt_w(ID_W, DEPTH),
  localparam int QW = clog2(DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              s_ar_valid,
  output logic              s_ar_ready,
  input  logic [ID_W-1:0]   s_ar_id,
  input  logic [USER_W-1:0] s_ar_user,
  output logic              m_ar_valid,
  input  logic              m_ar_ready,
  input  logic              m_r_valid,
  output logic              m_r_ready,
  input  logic [ID_W-1:0]   m_r_id,
  input  logic              m_r_last,
  output logic              s_r_valid,
  input  logic              s_r_ready,
  output logic [USER_W-1:0] s_r_user,
  input  logic              s_aw_valid,
  output logic              s_aw_ready,
  input  logic [ID_W-1:0]   s_aw_id,
  input  logic [USER_W-1:0] s_aw_user,
  output logic              m_aw_valid,
  input  logic              m_aw_ready,
  input  logic              m_b_valid,
  output logic              m_b_ready,
  input  logic [ID_W-1:0]   m_b_id,
  output logic              s_b_valid,
  input  logic              s_b_ready,
  output logic [USER_W-1:0] s_b_user,
  output logic [CNT_W-1:0]  rd_inflight,
  output logic [CNT_W-1:0]  wr_inflight,
  output logic              err_unexp,
  input  logic              err_clr
);
  logic [1:0][NUM_IDS-1:0] q_push, q_pop, q_full, q_empty;
  logic [USER_W-1:0] q_head [2][NUM_IDS];
  logic [QW-1:0] q_count [2][NUM_IDS];
  logic ar_full, aw_full, r_empty, b_empty;
  logic ar_fire, aw_fire, r_fire, b_fire, r_pop, b_pop, err_new;
  for (genvar c = 0; c < 2; c++) begin : g_ch
    for (genvar i = 0; i < NUM_IDS; i++) begin : g_id
      axi4_user_fifo #(.DEPTH(DEPTH), .USER_W(USER_W)) u_fifo (
        .clock(clock),
        .reset_n(reset_n),
        .push(q_push[c][i]),
        .push_data(c == int'(CH_RD) ? s_ar_user : s_aw_user),
        .pop(q_pop[c][i]),
        .head(q_head[c][i]),
        .full(q_full[c][i]),
        .empty(q_empty[c][i]),
        .count(q_count[c][i])
      );
    end
  end
  assign ar_full = q_full[CH_RD][s_ar_id];
  assign aw_full = q_full[CH_WR][s_aw_id];
  assign m_ar_valid = s_ar_valid & ~ar_full;
  assign s_ar_ready = m_ar_ready & ~ar_full;
  assign m_aw_valid = s_aw_valid & ~aw_full;
  assign s_aw_ready = m_aw_ready & ~aw_full;
  assign ar_fire = m_ar_valid & m_ar_ready;
  assign aw_fire = m_aw_valid & m_aw_ready;
  assign s_r_valid = m_r_valid;
  assign m_r_ready = s_r_ready;
  assign s_b_valid = m_b_valid;
  assign m_b_ready = s_b_ready;
  assign r_empty = q_empty[CH_RD][m_r_id];
  assign b_empty = q_empty[CH_WR][m_b_id];
  assign s_r_user = r_empty ? '0 : q_head[CH_RD][m_r_id];
  assign s_b_user = b_empty ? '0 : q_head[CH_WR][m_b_id];
  assign r_fire = m_r_valid & s_r_ready;
  assign b_fire = m_b_valid & s_b_ready;
  assign r_pop = r_fire & m_r_last & (q_count[CH_RD][m_r_id] != '0);
  assign b_pop = b_fire & (q_count[CH_WR][m_b_id] != '0);
  assign err_new = (r_fire & r_empty) | (b_fire & b_empty);
  // one-hot push/pop enables decoded from the request and response IDs
  always_comb begin
    q_push = '0;
    q_pop = '0;
    q_push[CH_RD][s_ar_id] = ar_fire;
    q_push[CH_WR][s_aw_id] = aw_fire;
    q_pop[CH_RD][m_r_id] = r_pop;
    q_pop[CH_WR][m_b_id] = b_pop;
  end
  // per-channel occupancy and sticky error; a new error beats a same-cycle clear
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      rd_inflight <= '0;
      wr_inflight <= '0;
      err_unexp <= 1'b0;
    end else begin
      rd_inflight <= rd_inflight + CNT_W'(ar_fire) - CNT_W'(r_pop);
      wr_inflight <= wr_inflight + CNT_W'(aw_fire) - CNT_W'(b_pop);
      err_unexp <= err_new | (err_unexp & ~err_clr);
    end
endmodule

// File: tb/tb_axi4_id_user_tracker.sv
// tb_axi4_id_user_tracker: directed plus random checking against per-ID queue model
module tb_axi4_id_user_tracker;
  localparam int ID_W = 2;
  localparam int DEPTH = 2;
  localparam int USER_W = 5;
  localparam int NUM_IDS = 4;
  localparam int CNT_W = 4;
  logic clock = 1'b0;
  logic reset_n;
  logic s_ar_valid, s_ar_ready, m_ar_valid, m_ar_ready;
  logic [ID_W-1:0] s_ar_id, m_r_id, s_aw_id, m_b_id;
  logic [USER_W-1:0] s_ar_user, s_r_user, s_aw_user, s_b_user;
  logic m_r_valid, m_r_ready, m_r_last, s_r_valid, s_r_ready;
  logic s_aw_valid, s_aw_ready, m_aw_valid, m_aw_ready;
  logic m_b_valid, m_b_ready, s_b_valid, s_b_ready;
  logic [CNT_W-1:0] rd_inflight, wr_inflight;
  logic err_unexp, err_clr;
  logic [USER_W-1:0] rq [NUM_IDS][$];
  logic [USER_W-1:0] wq [NUM_IDS][$];
  bit err_m;
  int vectors = 0;
  int miscompares = 0;

  axi4_id_user_tracker #(.ID_W(ID_W), .DEPTH(DEPTH), .USER_W(USER_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready), .s_ar_id(s_ar_id), .s_ar_user(s_ar_user),
    .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
    .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_id(m_r_id), .m_r_last(m_r_last),
    .s_r_valid(s_r_valid), .s_r_ready(s_r_ready), .s_r_user(s_r_user),
    .s_aw_valid(s_aw_valid), .s_aw_ready(s_aw_ready), .s_aw_id(s_aw_id), .s_aw_user(s_aw_user),
    .m_aw_valid(m_aw_valid), .m_aw_ready(m_aw_ready),
    .m_b_valid(m_b_valid), .m_b_ready(m_b_ready), .m_b_id(m_b_id),
    .s_b_valid(s_b_valid), .s_b_ready(s_b_ready), .s_b_user(s_b_user),
    .rd_inflight(rd_inflight), .wr_inflight(wr_inflight),
    .err_unexp(err_unexp), .err_clr(err_clr)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int total(input bit rd);
    int s = 0;
    for (int i = 0; i < NUM_IDS; i++) s += rd ? rq[i].size() : wq[i].size();
    return s;
  endfunction

  task automatic idle();
    s_ar_valid = 0; s_ar_id = 0; s_ar_user = 0; m_ar_ready = 0;
    m_r_valid = 0; m_r_id = 0; m_r_last = 0; s_r_ready = 0;
    s_aw_valid = 0; s_aw_id = 0; s_aw_user = 0; m_aw_ready = 0;
    m_b_valid = 0; m_b_id = 0; s_b_ready = 0; err_clr = 0;
  endtask

  task automatic clear_model();
    for (int i = 0; i < NUM_IDS; i++) begin
      rq[i].delete();
      wq[i].delete();
    end
    err_m = 0;
  endtask

  // called just after a falling edge with inputs applied; checks, updates model, advances one cycle
  task automatic cyc();
    bit ar_nf, aw_nf, r_emp, b_emp, ar_f, aw_f, r_f, b_f;
    logic [USER_W-1:0] r_exp, b_exp;
    #1;
    ar_nf = rq[s_ar_id].size() < DEPTH;
    aw_nf = wq[s_aw_id].size() < DEPTH;
    r_emp = rq[m_r_id].size() == 0;
    b_emp = wq[m_b_id].size() == 0;
    r_exp = r_emp ? '0 : rq[m_r_id][0];
    b_exp = b_emp ? '0 : wq[m_b_id][0];
    chk("m_ar_valid", m_ar_valid, s_ar_valid & ar_nf);
    chk("s_ar_ready", s_ar_ready, m_ar_ready & ar_nf);
    chk("m_aw_valid", m_aw_valid, s_aw_valid & aw_nf);
    chk("s_aw_ready", s_aw_ready, m_aw_ready & aw_nf);
    chk("s_r_valid", s_r_valid, m_r_valid);
    chk("m_r_ready", m_r_ready, s_r_ready);
    chk("s_b_valid", s_b_valid, m_b_valid);
    chk("m_b_ready", m_b_ready, s_b_ready);
    chk("s_r_user", s_r_user, r_exp);
    chk("s_b_user", s_b_user, b_exp);
    chk("rd_inflight", rd_inflight, total(1));
    chk("wr_inflight", wr_inflight, total(0));
    chk("err_unexp", err_unexp, err_m);
    ar_f = s_ar_valid & ar_nf & m_ar_ready;
    aw_f = s_aw_valid & aw_nf & m_aw_ready;
    r_f = m_r_valid & s_r_ready;
    b_f = m_b_valid & s_b_ready;
    if (r_f && !r_emp && m_r_last) void'(rq[m_r_id].pop_front());
    if (b_f && !b_emp) void'(wq[m_b_id].pop_front());
    if (ar_f) rq[s_ar_id].push_back(s_ar_user);
    if (aw_f) wq[s_aw_id].push_back(s_aw_user);
    err_m = (r_f & r_emp) | (b_f & b_emp) | (err_m & ~err_clr);
    @(negedge clock);
  endtask

  initial begin
    idle();
    clear_model();
    reset_n = 0;
    repeat (2) @(negedge clock);
    reset_n = 1;
    cyc();
    // single read round trip
    s_ar_valid = 1; s_ar_id = 1; s_ar_user = 5'h13; m_ar_ready = 1;
    cyc();
    idle(); m_r_valid = 1; m_r_id = 1; m_r_last = 1; s_r_ready = 1;
    cyc();
    idle();
    cyc();
    // write backpressure on id 2 with B stalled, then released by one B
    s_aw_valid = 1; s_aw_id = 2; m_aw_ready = 1;
    s_aw_user = 5'h04; cyc();
    s_aw_user = 5'h05; cyc();
    s_aw_user = 5'h06; cyc();
    m_b_valid = 1; m_b_id = 2; s_b_ready = 1;
    cyc();
    m_b_valid = 0;
    cyc();
    idle(); m_b_valid = 1; m_b_id = 2; s_b_ready = 1;
    cyc(); cyc();
    idle();
    cyc();
    // interleaved reads across ids 0 and 3
    m_ar_ready = 1; s_ar_valid = 1;
    s_ar_id = 0; s_ar_user = 5'h01; cyc();
    s_ar_id = 3; s_ar_user = 5'h02; cyc();
    s_ar_id = 0; s_ar_user = 5'h03; cyc();
    idle(); m_r_valid = 1; s_r_ready = 1; m_r_last = 1;
    m_r_id = 3; cyc();
    m_r_id = 0; cyc();
    m_r_id = 0; cyc();
    idle();
    // four-beat burst, pop only on the last beat
    s_ar_valid = 1; s_ar_id = 0; s_ar_user = 5'h0a; m_ar_ready = 1;
    cyc();
    idle(); m_r_valid = 1; m_r_id = 0; s_r_ready = 1;
    repeat (3) cyc();
    m_r_last = 1;
    cyc();
    idle();
    cyc();
    // unexpected B, sticky flag, clear, clear coincident with new error
    m_b_valid = 1; m_b_id = 1; s_b_ready = 1;
    cyc();
    idle();
    cyc(); cyc();
    err_clr = 1;
    cyc();
    idle();
    cyc();
    err_clr = 1; m_b_valid = 1; m_b_id = 1; s_b_ready = 1;
    cyc();
    idle();
    cyc();
    err_clr = 1;
    cyc();
    idle();
    // asynchronous reset with three entries outstanding
    s_ar_valid = 1; m_ar_ready = 1; s_ar_id = 2; s_ar_user = 5'h11; cyc();
    s_ar_id = 3; s_ar_user = 5'h12; cyc();
    idle(); s_aw_valid = 1; m_aw_ready = 1; s_aw_id = 0; s_aw_user = 5'h1f; cyc();
    idle();
    m_ar_ready = 1; s_ar_id = 2; m_r_id = 2; m_b_id = 0;
    #2 reset_n = 0;
    #1;
    chk("rst_rd_inflight", rd_inflight, 0);
    chk("rst_wr_inflight", wr_inflight, 0);
    chk("rst_err", err_unexp, 0);
    chk("rst_s_ar_ready", s_ar_ready, 1);
    chk("rst_s_r_user", s_r_user, 0);
    chk("rst_s_b_user", s_b_user, 0);
    clear_model();
    @(negedge clock);
    reset_n = 1;
    cyc();
    m_r_valid = 1; s_r_ready = 1; m_r_last = 1;
    cyc();
    idle();
    cyc();
    err_clr = 1;
    cyc();
    // random traffic
    for (int n = 0; n < 600; n++) begin
      s_ar_valid = $urandom_range(0, 1);
      s_ar_id = ID_W'($urandom);
      s_ar_user = USER_W'($urandom);
      m_ar_ready = $urandom_range(0, 3) != 0;
      s_aw_valid = $urandom_range(0, 1);
      s_aw_id = ID_W'($urandom);
      s_aw_user = USER_W'($urandom);
      m_aw_ready = $urandom_range(0, 3) != 0;
      m_r_valid = $urandom_range(0, 1);
      m_r_id = ID_W'($urandom);
      m_r_last = $urandom_range(0, 1);
      s_r_ready = $urandom_range(0, 3) != 0;
      m_b_valid = $urandom_range(0, 2) == 0;
      m_b_id = ID_W'($urandom);
      s_b_ready = $urandom_range(0, 3) != 0;
      err_clr = $urandom_range(0, 7) == 0;
      cyc();
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/axi4_id_user_tracker.md
# axi4_id_user_tracker

Parametrised AXI4 per-ID user-field tracker for the core's AXI4 master port edge. It records the request-side user bits (cacheability/privilege tag) for every AR and AW beat accepted downstream, keyed by transaction ID. It returns those bits on the matching R/B response. Compared with the fixed two-ID, single-entry-width tracker, it adds:
- configurable ID count, per-ID depth and user width;
- request backpressure on full;
- sticky unexpected-response detection;
- per-channel in-flight counts.

## Interface
Parameters:
- ID_W, 2: ID width. NUM_IDS = 2**ID_W.
- DEPTH, 2: entries per ID per channel. Power of two, ≥1.
- USER_W, 5: tracked user width.
- CNT_W, derived: clog2(NUM_IDS*DEPTH+1).

Ports (all payload fields other than id/user/last route around the block):
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous assert, active-low; deassertion synchronised externally
- s_ar_valid / s_ar_ready  in/out  1  upstream read request handshake
- s_ar_id  in  ID_W ; s_ar_user  in  USER_W
- m_ar_valid / m_ar_ready  out/in  1  downstream read request handshake
- m_r_valid / m_r_ready  in/out  1 ; m_r_id  in  ID_W ; m_r_last  in  1  downstream read response
- s_r_valid / s_r_ready  out/in  1 ; s_r_user  out  USER_W  upstream read response
- s_aw_*, m_aw_*, m_b_*, s_b_*  same shape as AR/R, without last
- rd_inflight, wr_inflight  out  CNT_W  occupied entries per channel
- err_unexp  out  1  sticky: response arrived for an empty ID queue
- err_clr  in  1  synchronous clear of err_unexp

## Operation
- The block holds 2×NUM_IDS independent FIFOs, one read and one write per ID. Each FIFO is DEPTH×USER_W.
- Request path is combinational:
  - m_x_valid = s_x_valid & ~full[id]
  - s_x_ready = m_x_ready & ~full[id]
  - Push queue[id] on m_x_valid & m_x_ready.
- Full uses the registered count only. A same-cycle pop does not free a slot for a push that cycle.
- Response path is combinational:
  - s_x_valid = m_x_valid; m_x_ready = s_x_ready.
  - s_x_user = head of queue[m_x_id] when non-empty, else 0.
- Pop:
  - R: on fire & m_r_last.
  - B: on every fire.
  - Non-last R beats leave the queue unchanged.
- Empty queue on a response fire: no pop, no pointer change, err_unexp ← 1. The response still completes (no stall).
- err_clr and a new error in the same cycle: error wins (err_unexp = 1).
- Simultaneous push and pop on one queue: both take effect; count is unchanged.
- Pointers wrap modulo DEPTH. Per-queue counts are CNT of DEPTH+1 states.
- rd_inflight/wr_inflight are registered sums, updated by +1, −1 or 0 per cycle.
- Reset values:
  - all pointers/counts 0;
  - err_unexp 0; rd_inflight/wr_inflight 0;
  - all queues empty. Because of this, ready outputs equal their downstream readys and s_x_user = 0.
- Reset mid-transfer discards all entries. Responses after reset raise err_unexp.

## Timing
- Zero-cycle latency on all four handshake paths; no registers in data paths.
- Storage updates on the clock edge of the fire.
- A pushed entry is visible at the head on the next cycle. A response in the push cycle reads the prior head or empty state (no bypass).
- Combinational dependencies:
  - s_x_ready depends on m_x_ready and s_x_id. It never depends on s_x_valid.
  - m_x_ready depends only on s_x_ready.
- Counts, full, empty and err_unexp are registered.

## Structure
- Package axi4_tracker_pkg holds:
  - the clog2 helper;
  - the derived CNT_W/NUM_IDS constants;
  - a channel enum {CH_RD, CH_WR}.
- Sub-module axi4_user_fifo, instantiated 2×NUM_IDS times. Ports:
  - push, push_data, pop;
  - head, full, empty, count.
- Top level contains:
  - ID decode (one-hot push/pop enables);
  - head/full mux by ID;
  - in-flight counters;
  - error flag.

## Test plan
- Reset, then AR id=1 user=0x13 with m_ar_ready=1 → accepted; rd_inflight=1. Next cycle R id=1 last=1 → s_r_user=0x13; rd_inflight=0.
- DEPTH=2: three AW on id=2 with B stalled → third sees s_aw_ready=0 and m_aw_valid=0. Then B id=2 fire → same cycle still blocked; next cycle accepts.
- Interleaved AR ids 0,3,0 users 0x01,0x02,0x03; responses 3,0,0 → users 0x02,0x01,0x03.
- Burst R id=0 with 4 beats, last on beat 4 → all beats carry the same user; rd_inflight drops only after beat 4.
- B id=1 with empty queue → s_b_user=0; err_unexp=1 next cycle and stays. err_clr → 0. err_clr coincident with a new empty-B → stays 1.
- Assert reset_n low mid-traffic with 3 entries → all outputs at reset values asynchronously; inflight=0 after release.
